// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment receive path.
// Codes are active-low: bit 6 = segment a ... bit 0 = segment g.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F_IDX = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A_CODE = 7'b0001000;
    localparam logic [6:0] SEG_B_CODE = 7'b1100000;
    localparam logic [6:0] SEG_C_CODE = 7'b0110001;
    localparam logic [6:0] SEG_D_CODE = 7'b1000010;
    localparam logic [6:0] SEG_E_CODE = 7'b0110000;
    localparam logic [6:0] SEG_F_CODE = 7'b0111000;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;

    typedef struct packed {
        logic       match;
        logic [3:0] nibble;
    } seg_dec_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational active-low segment pattern to hex nibble decoder.
// Unknown patterns report match=0 with a zero nibble.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output seg_dec_t   dec
);

    always_comb begin
        dec = '{match: 1'b1, nibble: 4'h0};
        unique case (seg_n)
            SEG_0:      dec.nibble = 4'h0;
            SEG_1:      dec.nibble = 4'h1;
            SEG_2:      dec.nibble = 4'h2;
            SEG_3:      dec.nibble = 4'h3;
            SEG_4:      dec.nibble = 4'h4;
            SEG_5:      dec.nibble = 4'h5;
            SEG_6:      dec.nibble = 4'h6;
            SEG_7:      dec.nibble = 4'h7;
            SEG_8:      dec.nibble = 4'h8;
            SEG_9:      dec.nibble = 4'h9;
            SEG_A_CODE: dec.nibble = 4'hA;
            SEG_B_CODE: dec.nibble = 4'hB;
            SEG_C_CODE: dec.nibble = 4'hC;
            SEG_D_CODE: dec.nibble = 4'hD;
            SEG_E_CODE: dec.nibble = 4'hE;
            SEG_F_CODE: dec.nibble = 4'hF;
            default:    dec.match  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a scanned active-low 7-seg bus with stability filtering.
// Define BLANK_DETECT_EN to accept the all-off pattern as a legal blank digit.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   hex,
    output logic [DIGITS-1:0]     dig_valid,
    output logic                  code_err,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(STABLE_CYC) + 1;
    localparam int W     = DIGITS + 7;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYC - 1);
    localparam logic [DIGITS-1:0] ONE     = DIGITS'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [W-1:0]      sync1, samp, samp_prev;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        state, state_next;
    logic [DIGITS-1:0] sel, seen;
    logic              changed, an_ok, accept, blank;
    seg_dec_t          dec;

    // Idle bus (no anode, all segments off) is the reset sample value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '1;
            samp      <= '1;
            samp_prev <= '1;
        end else begin
            sync1     <= {an_n, seg_n};
            samp      <= sync1;
            samp_prev <= samp;
        end
    end

    assign changed = (samp != samp_prev);
    assign sel     = ~samp[W-1:7];
    assign an_ok   = (sel != '0) && ((sel & (sel - ONE)) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (changed)
            cnt <= '0;
        else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:
                if (an_ok) state_next = SETTLE;
            SETTLE:
                if (changed) state_next = an_ok ? SETTLE : IDLE;
                else if (cnt == CNT_MAX) state_next = HOLD;
            HOLD:
                if (changed) state_next = an_ok ? SETTLE : IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    assign accept = (state == SETTLE) && !changed && (cnt == CNT_MAX);

    seg7_to_hex u_dec (
        .seg_n (samp[6:0]),
        .dec   (dec)
    );

`ifdef BLANK_DETECT_EN
    assign blank = (samp[6:0] == SEG_BLANK);
`else
    assign blank = 1'b0;
`endif

    // Later per-digit writes to seen override the frame clear on purpose.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex        <= '0;
            dig_valid  <= '0;
            seen       <= '0;
            code_err   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            code_err   <= 1'b0;
            frame_done <= 1'b0;
            if (clr) begin
                hex       <= '0;
                dig_valid <= '0;
                seen      <= '0;
            end else begin
                if (&seen) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end
                if (accept) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (sel[i]) begin
                            dig_valid[i] <= dec.match;
                            if (dec.match) begin
                                hex[4*i +: 4] <= dec.nibble;
                                seen[i]       <= 1'b1;
                            end else if (blank) begin
                                seen[i] <= 1'b1;
                            end
                        end
                    end
                    if (!dec.match && !blank)
                        code_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with a queue of expected display states.
// Pulse outputs are tallied by a negedge monitor and checked per step.
module tb_seg7_scan_decoder;
    import seg7_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        clr;
    logic [15:0] hex;
    logic [3:0]  dig_valid;
    logic        code_err;
    logic        frame_done;

    seg7_scan_decoder #(.DIGITS(4), .STABLE_CYC(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .clr        (clr),
        .hex        (hex),
        .dig_valid  (dig_valid),
        .code_err   (code_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] hex;
        logic [3:0]  valid;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   err_pulses = 0;
    int   fd_pulses = 0;

    always @(negedge clk) begin
        if (code_err === 1'b1)   err_pulses++;
        if (frame_done === 1'b1) fd_pulses++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [15:0] h,
                            input logic [3:0] v);
        exp_t e;
        e.tag = tag;
        e.hex = h;
        e.valid = v;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_val({e.tag, "_hex"}, {16'h0, hex}, {16'h0, e.hex});
            check_val({e.tag, "_valid"}, {28'h0, dig_valid}, {28'h0, e.valid});
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg);
        @(negedge clk);
        an_n  = an;
        seg_n = seg;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [6:0] scan_codes [4];
    logic [3:0] scan_an [4];
    int         exp_blank_err;

    initial begin
        scan_codes[0] = SEG_1;
        scan_codes[1] = SEG_2;
        scan_codes[2] = SEG_3;
        scan_codes[3] = SEG_4;
        scan_an[0] = 4'b1110;
        scan_an[1] = 4'b1101;
        scan_an[2] = 4'b1011;
        scan_an[3] = 4'b0111;
`ifdef BLANK_DETECT_EN
        exp_blank_err = 0;
`else
        exp_blank_err = 1;
`endif

        rst_n = 1'b0;
        clr   = 1'b0;
        an_n  = 4'hF;
        seg_n = SEG_BLANK;
        #1;
        push_exp("reset", 16'h0, 4'h0);
        pop_check();
        check_val("reset_err", {31'h0, code_err}, 32'd0);
        check_val("reset_fd", {31'h0, frame_done}, 32'd0);
        cycles(3);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(3);

        // Single digit: valid exactly STABLE_CYC+3 edges after the change.
        err_pulses = 0;
        drive(4'b1110, SEG_5);
        push_exp("d0_pre", 16'h0, 4'h0);
        push_exp("d0_acc", 16'h0005, 4'h1);
        cycles(18);
        pop_check();
        cycles(1);
        pop_check();
        cycles(21);
        push_exp("d0_hold", 16'h0005, 4'h1);
        pop_check();
        check_val("d0_no_err", err_pulses, 0);

        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        push_exp("clr", 16'h0, 4'h0);
        pop_check();

        // Full scan, one frame_done pulse expected.
        fd_pulses = 0;
        for (int d = 0; d < 4; d++) begin
            drive(scan_an[d], scan_codes[d]);
            cycles(20);
        end
        cycles(5);
        drive(4'hF, SEG_BLANK);
        cycles(20);
        push_exp("scan", 16'h4321, 4'hF);
        pop_check();
        check_val("scan_frame_done", fd_pulses, 1);

        // Unstable digit 1: toggling every 8 cycles never accepts.
        for (int k = 0; k < 8; k++) begin
            drive(4'b1101, k[0] ? SEG_8 : SEG_7);
            cycles(8);
        end
        drive(4'hF, SEG_BLANK);
        cycles(20);
        push_exp("toggle", 16'h4321, 4'hF);
        pop_check();

        // Unmatched code on digit 2.
        err_pulses = 0;
        drive(4'b1011, 7'b1111110);
        cycles(19);
        check_val("bad_err_on", {31'h0, code_err}, 32'd1);
        cycles(1);
        check_val("bad_err_off", {31'h0, code_err}, 32'd0);
        cycles(20);
        push_exp("bad", 16'h4321, 4'hB);
        pop_check();
        check_val("bad_err_count", err_pulses, 1);

        drive(4'hF, SEG_BLANK);
        cycles(20);
        err_pulses = 0;
        drive(4'b1011, SEG_BLANK);
        cycles(40);
        push_exp("blank", 16'h4321, 4'hB);
        pop_check();
        check_val("blank_err_count", err_pulses, exp_blank_err);

        // Two anodes low never accepts.
        drive(4'hF, SEG_BLANK);
        cycles(20);
        err_pulses = 0;
        drive(4'b1100, SEG_8);
        cycles(40);
        push_exp("two_an", 16'h4321, 4'hB);
        pop_check();
        check_val("two_an_err", err_pulses, 0);

        // clr asserted at the accepting edge wins; HOLD is not re-accepted.
        drive(4'b1110, SEG_9);
        cycles(18);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        push_exp("clr_acc", 16'h0, 4'h0);
        pop_check();
        cycles(10);
        push_exp("clr_hold", 16'h0, 4'h0);
        pop_check();

        // Async reset mid-HOLD.
        drive(4'hF, SEG_BLANK);
        cycles(20);
        drive(4'b1101, SEG_3);
        cycles(19);
        push_exp("pre_rst", 16'h0030, 4'h2);
        pop_check();
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("async_rst", 16'h0, 4'h0);
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;
        cycles(5);
        push_exp("post_rst", 16'h0, 4'h0);
        pop_check();

        check_val("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
